edabk_tx_arbiter: RTL and testbench
===================================

Name: edabk_tx_arbiter

Overview:
- Round-robin scheduler that shares one edabk_transmitter between NUM_REQ requesters.
- Accepts one DATA_WIDTH word per grant and issues a single-cycle start to the transmitter.
- Waits for finish, with a watchdog timeout, then reports completion to the granted requester.
- Sits in the bclk domain between the transmitter and the producer blocks (register file, command encoder, debug port).

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_WIDTH, `CFG_DATA_WIDTH, bits per transmitted word; must match the transmitter.
- TIMEOUT, 64, bclk cycles allowed in WAIT for tx_finish; must exceed the worst-case transmitter frame length in bclks.
- ID_WIDTH, $clog2(NUM_REQ), width of requester index.
- TO_WIDTH, $clog2(TIMEOUT+1), width of the watchdog counter.

Ports:
- bclk  input  1  baud clock; the only clock.
- reset_n  input  1  asynchronous reset, active low.
- req_valid  input  NUM_REQ  per-requester word-pending flag.
- req_data  input  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse.
- tx_start  output  1  start pulse to transmitter.
- tx_data  output  DATA_WIDTH  word to transmitter tx_in; registered.
- tx_finish  input  1  transmitter finish pulse.
- busy  output  1  high whenever state is not IDLE.
- grant_id  output  ID_WIDTH  index of the current or last granted requester.
- done_valid  output  1  one-cycle pulse: word transmitted successfully.
- timeout_err  output  1  one-cycle pulse: watchdog expired.

Behaviour:
- Reset values (asynchronous, reset_n low): state=IDLE; req_ready=0; tx_start=0; tx_data=0; busy=0; grant_id=0; done_valid=0; timeout_err=0; rr_ptr=0; watchdog counter=0.
- FSM states: IDLE, START, WAIT.
- IDLE, arbitration:
  - If any req_valid bit is set, select the first set bit searching upward from rr_ptr with wrap-around.
  - On the clock edge: capture tx_data <= selected word, grant_id <= index, rr_ptr <= index+1 mod NUM_REQ, go to START.
  - No valid bit set: stay in IDLE; all outputs low.
- START, exactly one cycle:
  - tx_start=1 and req_ready[grant_id]=1; watchdog cleared to 0.
  - Next state is WAIT.
  - tx_finish sampled here is ignored.
- WAIT:
  - tx_start=0; the watchdog increments each cycle.
  - tx_finish=1: done_valid pulses in the following cycle, state returns to IDLE.
  - Watchdog reaches TIMEOUT-1 without tx_finish: timeout_err pulses in the following cycle, state returns to IDLE.
  - tx_finish and expiry in the same cycle: finish wins; done_valid=1, timeout_err=0.
- Latency:
  - req_valid seen in IDLE at cycle 0 gives tx_start and req_ready at cycle 1.
  - tx_finish at cycle k gives done_valid and IDLE at k+1; the earliest next tx_start is k+2.
- Requester contract:
  - req_data must be stable from req_valid rise until the cycle after req_ready.
  - Dropping req_valid after capture does not cancel; the word is still sent.
  - A requester may keep req_valid high for back-to-back words; round-robin still rotates to other pending requesters first.
- Fairness: with all requesters valid, grants cycle 0,1,..,NUM_REQ-1,0. Starvation-free.
- tx_data and grant_id hold their values until the next capture.
- done_valid and timeout_err both refer to the current grant_id.
- Reset asserted mid-frame: immediate return to reset values; no done or timeout pulse is produced.
- After reset release the arbiter starts from IDLE; the transmitter is reset by the same reset_n.

Decomposition:
- Shared package edabk_tx_arbiter_pkg holds:
  - the state enum (IDLE/START/WAIT) as a 2-bit typedef;
  - the TIMEOUT default constant;
  - a function computing the round-robin pick from a valid vector and a pointer.
- One combinational sub-module edabk_rr_arbiter(NUM_REQ) takes req_valid and rr_ptr and returns any_valid and the grant index.
- The FSM, watchdog and output registers live in edabk_tx_arbiter.

Test Plan:
- Single requester: req_valid[2]=1, word 8'hA5; tx_finish 20 cycles after start.
  - Expect tx_start one cycle after valid, tx_data=8'hA5, req_ready=4'b0100, grant_id=2.
  - Expect done_valid exactly one cycle after tx_finish.
- All four valid continuously with distinct words 8'h10..8'h13.
  - Expect grant order 0,1,2,3,0.
  - Expect tx_data matching each grant, one start per finish, no overlapping starts.
- Timeout: grant requester 1, never assert tx_finish.
  - Expect timeout_err pulse 1 cycle after TIMEOUT cycles in WAIT, grant_id=1, return to IDLE, no done_valid.
  - A subsequent request is served normally.
- Simultaneous events:
  - tx_finish on the watchdog expiry cycle: only done_valid pulses.
  - tx_finish during START: ignored; done_valid comes only from a finish in WAIT.
- Reset mid-WAIT: drop reset_n for 2 cycles while busy.
  - Expect all outputs 0 asynchronously and rr_ptr=0.
  - The next request from requester 3 is granted normally.
- Early valid drop: req_valid[0] deasserted the cycle after capture.
  - Expect the word still transmitted and done_valid still pulsed for grant_id=0.

Source files
------------

// File: rtl/edabk_tx_arbiter_pkg.sv
// Shared types and helpers for the edabk transmitter arbiter: FSM state
// encoding, default watchdog length and the round-robin pick function.
package edabk_tx_arbiter_pkg;

  localparam int unsigned TX_ARB_TIMEOUT = 64;
  localparam int unsigned RR_MAX_REQ     = 16;
  localparam int unsigned RR_MAX_IDW     = 4;
  localparam int unsigned RR_CAND_W      = RR_MAX_IDW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } tx_arb_state_e;

  typedef struct packed {
    logic                  any;
    logic [RR_MAX_IDW-1:0] idx;
  } rr_pick_t;

  // First set bit of valid[n-1:0], searching upward from ptr with wrap.
  // ptr must be below n; the sum ptr+off stays under 2n so one subtract wraps it.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                       input logic [RR_MAX_IDW-1:0] ptr,
                                       input logic [RR_CAND_W-1:0]  n);
    rr_pick_t             res;
    logic [RR_CAND_W-1:0] cand;
    res = '0;
    for (int unsigned off = 0; off < RR_MAX_REQ; off++) begin
      cand = RR_CAND_W'(ptr) + RR_CAND_W'(off);
      if (cand >= n) begin
        cand = cand - n;
      end
      if ((RR_CAND_W'(off) < n) && !res.any && valid[cand[RR_MAX_IDW-1:0]]) begin
        res.any = 1'b1;
        res.idx = cand[RR_MAX_IDW-1:0];
      end
    end
    return res;
  endfunction

endpackage : edabk_tx_arbiter_pkg

// File: rtl/edabk_rr_arbiter.sv
// Combinational round-robin selector: picks the first valid requester at or
// above rr_ptr, wrapping at NUM_REQ.
module edabk_rr_arbiter
  import edabk_tx_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ  = 4,
  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic                any_valid_c,
  output logic [ID_WIDTH-1:0] grant_idx_c
);

  rr_pick_t pick;

  always_comb begin
    pick = rr_pick(RR_MAX_REQ'(req_valid), RR_MAX_IDW'(rr_ptr), RR_CAND_W'(NUM_REQ));
  end

  assign any_valid_c = pick.any;
  assign grant_idx_c = ID_WIDTH'(pick.idx);

endmodule : edabk_rr_arbiter

// File: rtl/edabk_tx_arbiter.sv
// Round-robin scheduler sharing one edabk_transmitter between NUM_REQ
// producers: grant, one-cycle start, wait for finish under a watchdog.
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module edabk_tx_arbiter
  import edabk_tx_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = `CFG_DATA_WIDTH,
  parameter  int unsigned TIMEOUT    = TX_ARB_TIMEOUT,
  localparam int unsigned ID_WIDTH   = $clog2(NUM_REQ),
  localparam int unsigned TO_WIDTH   = $clog2(TIMEOUT + 1)
) (
  input  logic                          bclk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_finish,
  output logic                          busy,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          done_valid,
  output logic                          timeout_err
);

  tx_arb_state_e         state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TO_WIDTH-1:0]   wdog_q, wdog_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic                  tx_start_q, tx_start_d;
  logic                  busy_q, busy_d;
  logic                  done_valid_q, done_valid_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  any_valid_c;
  logic [ID_WIDTH-1:0]   grant_idx_c;
  logic [DATA_WIDTH-1:0] sel_word_c;
  logic [ID_WIDTH-1:0]   next_ptr_c;

  edabk_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_valid   (req_valid),
    .rr_ptr      (rr_ptr_q),
    .any_valid_c (any_valid_c),
    .grant_idx_c (grant_idx_c)
  );

  assign sel_word_c = req_data[32'(grant_idx_c) * DATA_WIDTH +: DATA_WIDTH];
  assign next_ptr_c = (grant_idx_c == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                              : grant_idx_c + ID_WIDTH'(1);

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    wdog_d        = wdog_q;
    tx_data_d     = tx_data_q;
    grant_id_d    = grant_id_q;
    req_ready_d   = '0;
    tx_start_d    = 1'b0;
    done_valid_d  = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_valid_c) begin
          state_d     = START;
          tx_data_d   = sel_word_c;
          grant_id_d  = grant_idx_c;
          rr_ptr_d    = next_ptr_c;
          tx_start_d  = 1'b1;
          req_ready_d = NUM_REQ'(1) << grant_idx_c;
        end
      end
      START: begin
        // A finish seen here belongs to no frame of ours and is dropped.
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (tx_finish) begin
          done_valid_d = 1'b1;
          state_d      = IDLE;
        end else if (wdog_q == TO_WIDTH'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wdog_d = wdog_q + TO_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      wdog_q        <= '0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      wdog_q        <= wdog_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      req_ready_q   <= req_ready_d;
      tx_start_q    <= tx_start_d;
      busy_q        <= busy_d;
      done_valid_q  <= done_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign done_valid  = done_valid_q;
  assign timeout_err = timeout_err_q;

endmodule : edabk_tx_arbiter

// File: tb/tb_edabk_tx_arbiter.sv
// Directed bench for edabk_tx_arbiter: table of grant/finish transactions
// plus hand-written timeout, collision and reset sequences.
module tb_edabk_tx_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned TO   = 64;

  logic             bclk;
  logic             reset_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]  req_ready;
  logic             tx_start;
  logic [DW-1:0]    tx_data;
  logic             tx_finish;
  logic             busy;
  logic [1:0]       grant_id;
  logic             done_valid;
  logic             timeout_err;

  int n_applied = 0;
  int n_miscmp  = 0;

  edabk_tx_arbiter #(
    .NUM_REQ    (NREQ),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .bclk        (bclk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_finish   (tx_finish),
    .busy        (busy),
    .grant_id    (grant_id),
    .done_valid  (done_valid),
    .timeout_err (timeout_err)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  typedef struct {
    logic [NREQ-1:0]    mask;
    logic [NREQ*DW-1:0] data;
    int                 fin;
    logic [1:0]         gnt;
    logic [DW-1:0]      word;
    logic [NREQ-1:0]    rdy;
    bit                 drop;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One grant from an idle arbiter; finish is sampled v.fin cycles after start.
  task automatic do_txn(input string tag, input vec_t v);
    bit bad;
    req_valid = v.mask;
    req_data  = v.data;
    tick();
    chk({tag, "_start"}, 32'(tx_start), 32'd1);
    chk({tag, "_ready"}, 32'(req_ready), 32'(v.rdy));
    chk({tag, "_gnt"},   32'(grant_id), 32'(v.gnt));
    chk({tag, "_data"},  32'(tx_data), 32'(v.word));
    chk({tag, "_nodone"}, 32'(done_valid), 32'd0);
    if (v.drop) req_valid = '0;
    tick();
    chk({tag, "_start_off"}, 32'({tx_start, req_ready}), 32'd0);
    bad = 1'b0;
    for (int i = 2; i < v.fin; i++) begin
      tick();
      if (done_valid || timeout_err || tx_start || !busy) bad = 1'b1;
    end
    chk({tag, "_wait_quiet"}, 32'(bad), 32'd0);
    tx_finish = 1'b1;
    tick();
    tx_finish = 1'b0;
    chk({tag, "_done"},    32'({done_valid, timeout_err, busy}), 32'b100);
    chk({tag, "_done_gnt"}, 32'(grant_id), 32'(v.gnt));
    chk({tag, "_hold_data"}, 32'(tx_data), 32'(v.word));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    bit   bad;
    vec_t v;

    //          mask     data          fin gnt word   rdy      drop
    vecs[0] = '{4'b1111, 32'h13121110,  3, 2'd0, 8'h10, 4'b0001, 1'b0};
    vecs[1] = '{4'b1111, 32'h13121110,  5, 2'd1, 8'h11, 4'b0010, 1'b0};
    vecs[2] = '{4'b1111, 32'h13121110,  2, 2'd2, 8'h12, 4'b0100, 1'b0};
    vecs[3] = '{4'b1111, 32'h13121110,  4, 2'd3, 8'h13, 4'b1000, 1'b0};
    vecs[4] = '{4'b1111, 32'h13121110,  6, 2'd0, 8'h10, 4'b0001, 1'b0};
    vecs[5] = '{4'b0100, 32'h00A50000, 20, 2'd2, 8'hA5, 4'b0100, 1'b0};
    vecs[6] = '{4'b1001, 32'h3C0000C0,  2, 2'd3, 8'h3C, 4'b1000, 1'b0};
    vecs[7] = '{4'b1001, 32'h3C0000C0,  7, 2'd0, 8'hC0, 4'b0001, 1'b1};
    vecs[8] = '{4'b1110, 32'h77665544,  3, 2'd1, 8'h55, 4'b0010, 1'b0};

    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_finish = 1'b0;
    repeat (3) tick();
    chk("rst_outs", 32'({req_ready, tx_start, tx_data, busy, grant_id, done_valid, timeout_err}), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_quiet", 32'({req_ready, tx_start, busy, done_valid, timeout_err}), 32'd0);

    for (int i = 0; i < 9; i++) begin
      do_txn($sformatf("v%0d", i), vecs[i]);
    end

    // Watchdog expiry on requester 1; no finish ever arrives.
    req_valid = 4'b0010;
    req_data  = 32'h00005A00;
    tick();
    chk("to_start", 32'({tx_start, grant_id}), 32'b1_01);
    req_valid = '0;
    bad = 1'b0;
    for (int i = 0; i < int'(TO); i++) begin
      tick();
      if (timeout_err || done_valid || !busy) bad = 1'b1;
    end
    chk("to_quiet", 32'(bad), 32'd0);
    tick();
    chk("to_pulse", 32'({timeout_err, done_valid, busy}), 32'b100);
    chk("to_gnt", 32'(grant_id), 32'd1);
    tick();
    chk("to_pulse_end", 32'({timeout_err, busy}), 32'd0);

    v = '{4'b0001, 32'h000000E7, 3, 2'd0, 8'hE7, 4'b0001, 1'b1};
    do_txn("after_to", v);

    // Finish arrives on the very cycle the watchdog expires.
    req_valid = 4'b1000;
    req_data  = 32'h4D000000;
    tick();
    chk("exp_start", 32'({tx_start, grant_id}), 32'b1_11);
    req_valid = '0;
    repeat (TO) tick();
    tx_finish = 1'b1;
    tick();
    tx_finish = 1'b0;
    chk("exp_fin_wins", 32'({done_valid, timeout_err, busy}), 32'b100);
    tick();
    chk("exp_no_late_to", 32'({done_valid, timeout_err}), 32'd0);

    // Finish during START is ignored.
    req_valid = 4'b0100;
    req_data  = 32'h00990000;
    tick();
    chk("sf_start", 32'({tx_start, grant_id}), 32'b1_10);
    req_valid = '0;
    tx_finish = 1'b1;
    tick();
    tx_finish = 1'b0;
    chk("sf_ignored", 32'({done_valid, busy}), 32'b01);
    tick();
    chk("sf_still_wait", 32'({done_valid, busy}), 32'b01);
    tick();
    tx_finish = 1'b1;
    tick();
    tx_finish = 1'b0;
    chk("sf_done", 32'({done_valid, timeout_err, busy}), 32'b100);

    // Reset in the middle of WAIT.
    req_valid = 4'b0010;
    req_data  = 32'h00008800;
    tick();
    chk("rw_start", 32'({tx_start, grant_id}), 32'b1_01);
    req_valid = '0;
    repeat (3) tick();
    chk("rw_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rw_async", 32'({req_ready, tx_start, tx_data, busy, grant_id, done_valid, timeout_err}), 32'd0);
    tick();
    tick();
    chk("rw_held", 32'({req_ready, tx_start, tx_data, busy, grant_id, done_valid, timeout_err}), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("rw_no_pulse", 32'({done_valid, timeout_err, busy}), 32'd0);

    // rr_ptr back at 0: with 1 and 3 pending, requester 1 wins.
    v = '{4'b1010, 32'hB000B100, 4, 2'd1, 8'hB1, 4'b0010, 1'b1};
    do_txn("rw_ptr", v);
    v = '{4'b1000, 32'hD3000000, 3, 2'd3, 8'hD3, 4'b1000, 1'b1};
    do_txn("rw_req3", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
    $finish;
  end

endmodule : tb_edabk_tx_arbiter
